// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: allocates in tag order, retires in program order,
// frees committed pd_old registers and reports branch outcomes back to rename.

module rob_entry (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_alloc,
    input  logic [6:0]  i_pd_old,
    input  logic [31:0] i_pc,
    input  logic        i_set_done,
    input  logic        i_kill,
    output logic        o_valid,
    output logic        o_done,
    output logic [6:0]  o_pd_old,
    output logic [31:0] o_pc
);
    logic        r_valid;
    logic        r_done;
    logic [6:0]  r_pd_old;
    logic [31:0] r_pc;

    // Allocation wins over a same-cycle completion to this slot: that completion is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_pd_old <= 7'd0;
            r_pc     <= 32'd0;
        end else if (i_alloc) begin
            r_valid  <= 1'b1;
            r_done   <= 1'b0;
            r_pd_old <= i_pd_old;
            r_pc     <= i_pc;
        end else begin
            if (i_set_done) r_done  <= 1'b1;
            if (i_kill)     r_valid <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_done   = r_done;
    assign o_pd_old = r_pd_old;
    assign o_pc     = r_pc;
endmodule

module reorder_buffer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [3:0]  tag_in,
    input  logic [6:0]  pd_new_in,
    input  logic [6:0]  pd_old_in,
    input  logic [31:0] pc_in,
    input  logic        cmpl_valid,
    input  logic [3:0]  cmpl_tag,
    input  logic        br_valid,
    input  logic [3:0]  br_tag,
    input  logic        br_mispredict,
    output logic        write_en,
    output logic [6:0]  rob_data_out,
    output logic        mispredict,
    output logic        hit,
    output logic [4:0]  mispredict_tag,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [3:0]  commit_tag,
    output logic        tag_err
);
    logic [3:0]  r_head;
    logic [3:0]  r_tail;
    logic [4:0]  r_count;
    logic        r_tag_err;
    logic        r_write_en;
    logic [6:0]  r_rob_data;
    logic        r_mispredict;
    logic        r_hit;
    logic [4:0]  r_mp_tag;
    logic        r_commit_valid;
    logic [31:0] r_commit_pc;
    logic [3:0]  r_commit_tag;

    logic [DEPTH-1:0]       w_valid;
    logic [DEPTH-1:0]       w_done;
    logic [DEPTH-1:0]       w_alloc;
    logic [DEPTH-1:0]       w_set_done;
    logic [DEPTH-1:0]       w_kill;
    logic [DEPTH-1:0][6:0]  w_pd_old;
    logic [DEPTH-1:0][31:0] w_pc;

    logic       w_br_ok;
    logic       w_squash;
    logic       w_commit;
    logic       w_disp;
    logic [3:0] w_br_off;
    logic [4:0] w_n_after;
    logic       w_unused_pd_new;

    // Squashed pd_new values are recovered by rename from its checkpoint.
    assign w_unused_pd_new = ^pd_new_in;

    assign ready_in  = !reset && (r_count != 5'd16) && !r_mispredict;
    assign w_br_ok   = br_valid && w_valid[br_tag];
    assign w_squash  = w_br_ok && br_mispredict;
    assign w_commit  = (r_count != 5'd0) && w_valid[r_head] && w_done[r_head];
    assign w_disp    = valid_in && ready_in && !w_squash;
    assign w_br_off  = br_tag - r_head;
    // Younger entries behind the branch; derived from count so a full ring squashes correctly.
    assign w_n_after = r_count - {1'b0, w_br_off} - 5'd1;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        localparam logic [3:0] IDX = 4'(i);
        logic [3:0] w_rel;
        assign w_rel         = IDX - br_tag - 4'd1;
        assign w_alloc[i]    = w_disp && (r_tail == IDX);
        assign w_set_done[i] = (cmpl_valid && (cmpl_tag == IDX) && w_valid[i]) ||
                               (w_br_ok && (br_tag == IDX));
        assign w_kill[i]     = (w_squash && ({1'b0, w_rel} < w_n_after)) ||
                               (w_commit && (r_head == IDX));

        rob_entry u_ent (
            .clk        (clk),
            .reset      (reset),
            .i_alloc    (w_alloc[i]),
            .i_pd_old   (pd_old_in),
            .i_pc       (pc_in),
            .i_set_done (w_set_done[i]),
            .i_kill     (w_kill[i]),
            .o_valid    (w_valid[i]),
            .o_done     (w_done[i]),
            .o_pd_old   (w_pd_old[i]),
            .o_pc       (w_pc[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head    <= 4'd0;
            r_tail    <= 4'd0;
            r_count   <= 5'd0;
            r_tag_err <= 1'b0;
        end else begin
            r_head <= r_head + {3'd0, w_commit};
            if (w_squash) begin
                r_tail  <= br_tag + 4'd1;
                r_count <= {1'b0, w_br_off} + 5'd1 - {4'd0, w_commit};
            end else begin
                r_tail  <= r_tail + {3'd0, w_disp};
                r_count <= r_count + {4'd0, w_disp} - {4'd0, w_commit};
            end
            if (w_disp && (tag_in != r_tail)) r_tag_err <= 1'b1;
        end
    end

    // Strobes are single-cycle; their data fields hold until the next event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_en     <= 1'b0;
            r_rob_data     <= 7'd0;
            r_mispredict   <= 1'b0;
            r_hit          <= 1'b0;
            r_mp_tag       <= 5'd0;
            r_commit_valid <= 1'b0;
            r_commit_pc    <= 32'd0;
            r_commit_tag   <= 4'd0;
        end else begin
            r_commit_valid <= w_commit;
            r_write_en     <= w_commit && (w_pd_old[r_head] != 7'd0);
            r_mispredict   <= w_squash;
            r_hit          <= w_br_ok && !br_mispredict;
            if (w_commit) begin
                r_commit_pc  <= w_pc[r_head];
                r_commit_tag <= r_head;
                if (w_pd_old[r_head] != 7'd0) r_rob_data <= w_pd_old[r_head];
            end
            if (w_br_ok) r_mp_tag <= {1'b0, br_tag};
        end
    end

    assign write_en       = r_write_en;
    assign rob_data_out   = r_rob_data;
    assign mispredict     = r_mispredict;
    assign hit            = r_hit;
    assign mispredict_tag = r_mp_tag;
    assign commit_valid   = r_commit_valid;
    assign commit_pc      = r_commit_pc;
    assign commit_tag     = r_commit_tag;
    assign tag_err        = r_tag_err;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: ordered retirement, full/wrap, branch squash/hit,
// mid-run reset and sticky tag error.

module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [3:0]  tag_in;
    logic [6:0]  pd_new_in;
    logic [6:0]  pd_old_in;
    logic [31:0] pc_in;
    logic        cmpl_valid;
    logic [3:0]  cmpl_tag;
    logic        br_valid;
    logic [3:0]  br_tag;
    logic        br_mispredict;
    logic        write_en;
    logic [6:0]  rob_data_out;
    logic        mispredict;
    logic        hit;
    logic [4:0]  mispredict_tag;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [3:0]  commit_tag;
    logic        tag_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] pdb [4];

    reorder_buffer #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .tag_in(tag_in), .pd_new_in(pd_new_in), .pd_old_in(pd_old_in), .pc_in(pc_in),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .br_valid(br_valid),
        .br_tag(br_tag), .br_mispredict(br_mispredict), .write_en(write_en),
        .rob_data_out(rob_data_out), .mispredict(mispredict), .hit(hit),
        .mispredict_tag(mispredict_tag), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_tag(commit_tag), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] t, input logic [6:0] pd, input logic [31:0] pc);
        valid_in  = 1'b1;
        tag_in    = t;
        pd_old_in = pd;
        pd_new_in = 7'h11;
        pc_in     = pc;
        tick();
        valid_in  = 1'b0;
    endtask

    task automatic cmpl(input logic [3:0] t);
        cmpl_valid = 1'b1;
        cmpl_tag   = t;
        tick();
        cmpl_valid = 1'b0;
    endtask

    task automatic chk_commit(input string tg, input logic [3:0] t, input logic we, input logic [6:0] d);
        chk({tg, "_cv"},  32'(commit_valid), 32'd1);
        chk({tg, "_tag"}, 32'(commit_tag),   32'(t));
        chk({tg, "_we"},  32'(write_en),     32'(we));
        if (we) chk({tg, "_data"}, 32'(rob_data_out), 32'(d));
    endtask

    initial begin
        pdb = '{7'h21, 7'h00, 7'h23, 7'h24};
        reset = 1'b1; valid_in = 0; tag_in = 0; pd_new_in = 0; pd_old_in = 0; pc_in = 0;
        cmpl_valid = 0; cmpl_tag = 0; br_valid = 0; br_tag = 0; br_mispredict = 0;
        tick(); tick();
        chk("rst_ready", 32'(ready_in), 32'd0);
        chk("rst_cv", 32'(commit_valid), 32'd0);
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_mp", 32'(mispredict), 32'd0);
        reset = 1'b0; #1;
        chk("rel_ready", 32'(ready_in), 32'd1);
        chk("rel_count", 32'(dut.r_count), 32'd0);

        // Out-of-order completion, in-order retirement
        for (int t = 0; t < 4; t++) disp(4'(t), pdb[t], 32'h100 + 4 * t);
        cmpl(4'd3);
        cmpl(4'd1);
        cmpl(4'd0);
        chk("b_nocommit", 32'(commit_valid), 32'd0);
        cmpl(4'd2);
        chk_commit("b_c0", 4'd0, 1'b1, 7'h21);
        chk("b_c0_pc", commit_pc, 32'h100);
        tick(); chk_commit("b_c1", 4'd1, 1'b0, 7'h00);
        tick(); chk_commit("b_c2", 4'd2, 1'b1, 7'h23);
        tick(); chk_commit("b_c3", 4'd3, 1'b1, 7'h24);
        chk("b_c3_pc", commit_pc, 32'h10c);
        tick();
        chk("b_idle_cv", 32'(commit_valid), 32'd0);
        chk("b_count", 32'(dut.r_count), 32'd0);

        // Mispredict on tag 7 with head=4: same-cycle dispatch and squashed completion dropped
        for (int t = 4; t <= 10; t++) disp(4'(t), 7'(8'h30 + t), 32'h200 + 4 * t);
        chk("m_count7", 32'(dut.r_count), 32'd7);
        br_valid = 1; br_tag = 4'd7; br_mispredict = 1;
        valid_in = 1; tag_in = 4'd11; pd_old_in = 7'h3b; pc_in = 32'h22c;
        cmpl_valid = 1; cmpl_tag = 4'd9;
        tick();
        br_valid = 0; br_mispredict = 0; valid_in = 0; cmpl_valid = 0;
        chk("m_pulse", 32'(mispredict), 32'd1);
        chk("m_tag", 32'(mispredict_tag), 32'd7);
        chk("m_nohit", 32'(hit), 32'd0);
        chk("m_ready0", 32'(ready_in), 32'd0);
        chk("m_tail", 32'(dut.r_tail), 32'd8);
        chk("m_count", 32'(dut.r_count), 32'd4);
        valid_in = 1; tag_in = 4'd8; pd_old_in = 7'h48; pc_in = 32'h220;
        cmpl_valid = 1; cmpl_tag = 4'd9;
        tick();
        valid_in = 0; cmpl_valid = 0;
        chk("m_pulse_end", 32'(mispredict), 32'd0);
        chk("m_drop_count", 32'(dut.r_count), 32'd4);
        chk("m_drop_tail", 32'(dut.r_tail), 32'd8);
        chk("m_ready1", 32'(ready_in), 32'd1);
        disp(4'd8, 7'h48, 32'h220);
        chk("m_redisp_count", 32'(dut.r_count), 32'd5);
        chk("m_redisp_tail", 32'(dut.r_tail), 32'd9);
        chk("m_tag_err", 32'(tag_err), 32'd0);
        cmpl(4'd4); chk("m_nocommit", 32'(commit_valid), 32'd0);
        cmpl(4'd5); chk_commit("m_c4", 4'd4, 1'b1, 7'h34);
        cmpl(4'd6); chk_commit("m_c5", 4'd5, 1'b1, 7'h35);
        cmpl(4'd8); chk_commit("m_c6", 4'd6, 1'b1, 7'h36);
        tick();     chk_commit("m_c7", 4'd7, 1'b1, 7'h37);
        tick();     chk_commit("m_c8", 4'd8, 1'b1, 7'h48);
        chk("m_c8_pc", commit_pc, 32'h220);
        tick();
        chk("m_idle_cv", 32'(commit_valid), 32'd0);
        chk("m_empty", 32'(dut.r_count), 32'd0);

        // Reset with 5 live entries
        for (int t = 9; t <= 13; t++) disp(4'(t), 7'h12, 32'h300 + 4 * t);
        chk("r_count5", 32'(dut.r_count), 32'd5);
        #2 reset = 1'b1; #1;
        chk("r_ready", 32'(ready_in), 32'd0);
        chk("r_count", 32'(dut.r_count), 32'd0);
        chk("r_pc", commit_pc, 32'd0);
        chk("r_ctag", 32'(commit_tag), 32'd0);
        chk("r_data", 32'(rob_data_out), 32'd0);
        chk("r_mptag", 32'(mispredict_tag), 32'd0);
        tick();
        reset = 1'b0; #1;
        chk("r_rel_ready", 32'(ready_in), 32'd1);
        chk("r_rel_tail", 32'(dut.r_tail), 32'd0);

        // Fill to 16, refuse extra, reopen on commit and wrap to tag 0
        for (int t = 0; t < 16; t++)
            disp(4'(t), (t == 2) ? 7'h00 : 7'(8'h40 + t), 32'h1000 + 4 * t);
        chk("f_count", 32'(dut.r_count), 32'd16);
        chk("f_ready", 32'(ready_in), 32'd0);
        disp(4'd0, 7'h55, 32'h5555);
        chk("f_extra_count", 32'(dut.r_count), 32'd16);
        chk("f_extra_tail", 32'(dut.r_tail), 32'd0);
        chk("f_extra_err", 32'(tag_err), 32'd0);
        cmpl(4'd0);
        chk("f_still_full", 32'(ready_in), 32'd0);
        tick();
        chk_commit("f_c0", 4'd0, 1'b1, 7'h40);
        chk("f_reopen", 32'(ready_in), 32'd1);
        disp(4'd0, 7'h50, 32'h2000);
        chk("f_wrap_count", 32'(dut.r_count), 32'd16);
        chk("f_wrap_err", 32'(tag_err), 32'd0);
        chk("f_wrap_ready", 32'(ready_in), 32'd0);
        cmpl(4'd1);
        tick();
        chk_commit("f_c1", 4'd1, 1'b1, 7'h41);
        chk("f_count15", 32'(dut.r_count), 32'd15);

        // Correct prediction on the head branch, pd_old=0
        br_valid = 1; br_tag = 4'd2; br_mispredict = 0;
        tick();
        br_valid = 0;
        chk("h_hit", 32'(hit), 32'd1);
        chk("h_tag", 32'(mispredict_tag), 32'd2);
        chk("h_nomp", 32'(mispredict), 32'd0);
        chk("h_nocommit", 32'(commit_valid), 32'd0);
        tick();
        chk("h_hit_end", 32'(hit), 32'd0);
        chk_commit("h_c2", 4'd2, 1'b0, 7'h00);
        chk("h_c2_pc", commit_pc, 32'h1008);

        // Sticky tag error
        chk("e_tail", 32'(dut.r_tail), 32'd1);
        disp(4'd6, 7'h66, 32'h3000);
        chk("e_set", 32'(tag_err), 32'd1);
        chk("e_written_tail", 32'(dut.r_tail), 32'd2);
        tick(); tick(); tick();
        chk("e_sticky", 32'(tag_err), 32'd1);
        reset = 1'b1; #1;
        chk("e_cleared", 32'(tag_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
